// File: rtl/band_mixer.sv
// band_mixer: serial multiply-accumulate mixer of NUM_BANDS gained band samples into one saturated output
module band_mixer #(
  parameter int NUM_BANDS = 8,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
  input  logic                          band_valid,
  input  logic [NUM_BANDS*GAIN_W-1:0]   gain_in,
  output logic signed [DATA_W-1:0]      mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int IDX_W  = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state_q, state_d;
  logic [NUM_BANDS*DATA_W-1:0] band_q, band_d;
  logic [NUM_BANDS*GAIN_W-1:0] gain_q, gain_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, shifted;
  logic signed [DATA_W-1:0] mix_out_q, mix_out_d, cur_band;
  logic [GAIN_W-1:0] cur_gain;
  logic signed [PROD_W-1:0] prod;
  logic mix_valid_q, mix_valid_d, busy_q, busy_d, overrun_q, overrun_d;
  assign cur_band = band_q[int'(idx_q)*DATA_W +: DATA_W];
  assign cur_gain = gain_q[int'(idx_q)*GAIN_W +: GAIN_W];
  assign prod     = PROD_W'(cur_band) * PROD_W'($signed({1'b0, cur_gain}));
  assign shifted  = acc_q >>> GAIN_FRAC;
  always_comb begin
    state_d     = state_q;
    band_d      = band_q;
    gain_d      = gain_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    mix_out_d   = mix_out_q;
    busy_d      = busy_q;
    mix_valid_d = 1'b0;
    overrun_d   = 1'b0;
    if (clk_enable) begin
      overrun_d = band_valid && state_q != IDLE;
      case (state_q)
        IDLE: if (band_valid) begin
          band_d  = band_in;
          gain_d  = gain_in;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
        MAC: begin
          acc_d   = acc_q + ACC_W'(prod);
          idx_d   = idx_q + IDX_W'(1);
          state_d = int'(idx_q) == NUM_BANDS - 1 ? OUT : MAC;
        end
        OUT: begin
          mix_out_d   = shifted > MAX_V ? MAX_V[DATA_W-1:0] :
                        shifted < MIN_V ? MIN_V[DATA_W-1:0] : shifted[DATA_W-1:0];
          mix_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      band_q      <= '0;
      gain_q      <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      band_q      <= band_d;
      gain_q      <= gain_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: scoreboard bench for band_mixer with directed vectors
module tb_band_mixer;
  logic clk = 1'b0;
  logic rst, clk_enable, band_valid;
  logic [127:0] band_in;
  logic [63:0] gain_in;
  logic signed [15:0] mix_out;
  logic mix_valid, busy, overrun;
  int checks = 0, errors = 0, cyc = 0, ovr_cnt = 0;
  int exp_q[$];
  int due_q[$];
  band_mixer dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .band_in(band_in),
    .band_valid(band_valid), .gain_in(gain_in), .mix_out(mix_out),
    .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (mix_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mix_valid got %0d at cycle %0d", mix_out, cyc);
      end else begin
        int e, d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (int'(mix_out) != e) begin
          errors++;
          $display("FAIL mix_out got %0d exp %0d", mix_out, e);
        end
        checks++;
        if (cyc != d) begin
          errors++;
          $display("FAIL latency got cycle %0d exp %0d", cyc, d);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_valid got %0b exp 0", busy);
        end
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_all(input int b, input int g);
    for (int k = 0; k < 8; k++) begin
      band_in[k*16 +: 16] = 16'(b);
      gain_in[k*8 +: 8]   = 8'(g);
    end
  endtask
  task automatic send(input int e, input int stall, input bit push);
    band_valid = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 10 + stall);
    end
    step(1);
    band_valid = 1'b0;
  endtask
  task automatic wait_done;
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout pending %0d exp 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask
  initial begin
    int o;
    rst = 1'b1; clk_enable = 1'b1; band_valid = 1'b0;
    set_all(0, 0);
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mix_out", int'(mix_out), 0);
    chk("rst_mix_valid", int'(mix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    step(1);
    set_all(1000, 64);
    send(8000, 0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy_mac", int'(busy), 1);
    end
    wait_done();
    set_all(0, 0);
    band_in[3*16 +: 16] = -16'sd100;
    gain_in[3*8 +: 8] = 8'd96;
    send(-150, 0, 1);
    wait_done();
    set_all(32767, 255);
    send(32767, 0, 1);
    wait_done();
    set_all(-32768, 255);
    send(-32768, 0, 1);
    wait_done();
    set_all(0, 0);
    band_in[15:0] = 16'd1;
    gain_in[7:0] = 8'd1;
    send(0, 0, 1);
    wait_done();
    band_in[15:0] = 16'hFFFF;
    send(-1, 0, 1);
    wait_done();
    o = ovr_cnt;
    set_all(1000, 64);
    send(8000, 0, 1);
    step(2);
    set_all(5, 64);
    send(0, 0, 0);
    wait_done();
    set_all(200, 128);
    send(3200, 0, 1);
    wait_done();
    step(1);
    chk("overrun_once", ovr_cnt - o, 1);
    o = ovr_cnt;
    set_all(1000, 64);
    send(8000, 5, 1);
    step(3);
    set_all(0, 0);
    clk_enable = 1'b0;
    band_valid = 1'b1;
    step(5);
    band_valid = 1'b0;
    clk_enable = 1'b1;
    wait_done();
    step(1);
    chk("no_overrun_when_disabled", ovr_cnt - o, 0);
    set_all(1000, 64);
    send(0, 0, 0);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mix_out", int'(mix_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mix_valid", int'(mix_valid), 0);
    step(12);
    rst = 1'b1;
    band_valid = 1'b1;
    step(1);
    rst = 1'b0;
    band_valid = 1'b0;
    @(negedge clk);
    chk("rst_wins_busy", int'(busy), 0);
    step(12);
    set_all(0, 0);
    band_in[3*16 +: 16] = -16'sd100;
    gain_in[3*8 +: 8] = 8'd96;
    send(-150, 0, 1);
    wait_done();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
